// File: rtl/pc_ras.sv
// pc_ras: program counter with an integrated return-address stack.
// Chooses the next instruction-fetch address each cycle. In priority order the
// sources are: a popped return address, a call target, a branch target, and the
// sequential increment. Calls push the address after the current one onto a
// circular return stack. When the stack is full, a push overwrites the oldest entry.
// Ports:
//   Clk1         clock; all state updates on its rising edge
//   rst          synchronous active-high reset, overrides every other input
//   stall        hold all state; requests presented this cycle are dropped
//   branch_en    jump to branch_addr
//   branch_addr  branch target
//   call_en      push iAddr+INC and jump to call_addr
//   call_addr    call target
//   ret_en       pop top of stack into iAddr (increment if the stack is empty)
//   iAddr        registered fetch address
//   ras_count    number of valid stack entries
//   ras_full     registered: ras_count == RAS_DEPTH
//   ras_empty    registered: ras_count == 0
//   ras_ovf      sticky: a push happened while full
//   ras_unf      sticky: a pop happened while empty
module pc_ras #(
    parameter int unsigned ADDR_W    = 32'd16,
    parameter int unsigned RST_VEC   = 32'd0,
    parameter int unsigned INC       = 32'd1,
    parameter int unsigned RAS_DEPTH = 32'd8
) (
    input  logic                             Clk1,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             branch_en,
    input  logic [ADDR_W-1:0]                branch_addr,
    input  logic                             call_en,
    input  logic [ADDR_W-1:0]                call_addr,
    input  logic                             ret_en,
    output logic [ADDR_W-1:0]                iAddr,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_full,
    output logic                             ras_empty,
    output logic                             ras_ovf,
    output logic                             ras_unf
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 32'd1);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RST_VEC);
    localparam logic [ADDR_W-1:0] INC_VAL  = ADDR_W'(INC);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(RAS_DEPTH - 32'd1);

    // The write pointer indexes the slot that the next push fills.
    // The top entry sits one slot below it, modulo RAS_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_MAX) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(0)) begin
            return PTR_MAX;
        end else begin
            return p - PTR_W'(1);
        end
    endfunction

    logic [ADDR_W-1:0] iaddr_r;
    logic [ADDR_W-1:0] stack_r [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_r;
    logic              empty_r;
    logic              ovf_r;
    logic              unf_r;

    logic [ADDR_W-1:0] seq_addr_s;
    logic [ADDR_W-1:0] iaddr_nxt_s;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              ovf_nxt_s;
    logic              unf_nxt_s;
    logic              push_s;

    // The sequential address wraps modulo 2^ADDR_W because of the operand width.
    assign seq_addr_s = iaddr_r + INC_VAL;

    // Next-state selection; priority is stall > ret > call > branch > increment.
    always_comb begin
        iaddr_nxt_s  = iaddr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        ovf_nxt_s    = ovf_r;
        unf_nxt_s    = unf_r;
        push_s       = 1'b0;
        if (stall) begin
            iaddr_nxt_s = iaddr_r;
        end else if (ret_en) begin
            if (count_r != CNT_W'(0)) begin
                iaddr_nxt_s  = stack_r[ptr_dec(wr_ptr_r)];
                wr_ptr_nxt_s = ptr_dec(wr_ptr_r);
                count_nxt_s  = count_r - CNT_W'(1);
            end else begin
                iaddr_nxt_s = seq_addr_s;
                unf_nxt_s   = 1'b1;
            end
        end else if (call_en) begin
            push_s       = 1'b1;
            iaddr_nxt_s  = call_addr;
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
            // When full, the write slot already holds the oldest entry,
            // so the push replaces it and the count stays at RAS_DEPTH.
            if (count_r == DEPTH_C) begin
                ovf_nxt_s = 1'b1;
            end else begin
                count_nxt_s = count_r + CNT_W'(1);
            end
        end else if (branch_en) begin
            iaddr_nxt_s = branch_addr;
        end else begin
            iaddr_nxt_s = seq_addr_s;
        end
    end

    // Control state registers. full and empty are decoded from the next count
    // so that they stay aligned with the registered ras_count.
    always_ff @(posedge Clk1) begin
        if (rst) begin
            iaddr_r  <= RST_ADDR;
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            iaddr_r  <= iaddr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_C);
            empty_r  <= (count_nxt_s == CNT_W'(0));
            ovf_r    <= ovf_nxt_s;
            unf_r    <= unf_nxt_s;
        end
    end

    // Stack storage is not reset; its contents are meaningless while count is 0.
    always_ff @(posedge Clk1) begin
        if (rst) begin
            stack_r <= stack_r;
        end else if (push_s) begin
            stack_r[wr_ptr_r] <= seq_addr_s;
        end else begin
            stack_r <= stack_r;
        end
    end

    assign iAddr     = iaddr_r;
    assign ras_count = count_r;
    assign ras_full  = full_r;
    assign ras_empty = empty_r;
    assign ras_ovf   = ovf_r;
    assign ras_unf   = unf_r;

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: scoreboard testbench for pc_ras.
// A reference model keeps the return stack as a queue of addresses. For every
// issued cycle, the model's expected outputs go into a queue. A monitor pops one
// entry after each clock edge and compares it with the DUT outputs. Directed
// scenarios add fixed-value spot checks. A randomized phase follows them.
module tb_pc_ras;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] RSTV = 16'h0000;
    localparam logic [ADDR_W-1:0] INCV = 16'h0001;

    typedef struct {
        logic [ADDR_W-1:0] iaddr;
        logic [CNT_W-1:0]  cnt;
        logic              full;
        logic              empty;
        logic              ovf;
        logic              unf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stall = 1'b0;
    logic              branch_en = 1'b0;
    logic [ADDR_W-1:0] branch_addr = '0;
    logic              call_en = 1'b0;
    logic [ADDR_W-1:0] call_addr = '0;
    logic              ret_en = 1'b0;
    logic [ADDR_W-1:0] iaddr;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_full, ras_empty, ras_ovf, ras_unf;

    int tests  = 0;
    int failed = 0;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] m_stack[$];
    logic [ADDR_W-1:0] m_iaddr = RSTV;
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;

    pc_ras #(.ADDR_W(ADDR_W), .RST_VEC(0), .INC(1), .RAS_DEPTH(DEPTH)) dut (
        .Clk1(clk), .rst(rst), .stall(stall),
        .branch_en(branch_en), .branch_addr(branch_addr),
        .call_en(call_en), .call_addr(call_addr), .ret_en(ret_en),
        .iAddr(iaddr), .ras_count(ras_count), .ras_full(ras_full),
        .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour: push/pop on an address queue capped at DEPTH entries.
    task automatic model_step(input logic r, input logic s, input logic b, input logic [ADDR_W-1:0] ba,
                              input logic c, input logic [ADDR_W-1:0] ca, input logic rt);
        exp_t e;
        if (r) begin
            m_iaddr = RSTV;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (s) begin
            m_iaddr = m_iaddr;
        end else if (rt) begin
            if (m_stack.size() > 0) begin
                m_iaddr = m_stack.pop_back();
            end else begin
                m_iaddr = m_iaddr + INCV;
                m_unf = 1'b1;
            end
        end else if (c) begin
            m_stack.push_back(m_iaddr + INCV);
            if (m_stack.size() > DEPTH) begin
                void'(m_stack.pop_front());
                m_ovf = 1'b1;
            end
            m_iaddr = ca;
        end else if (b) begin
            m_iaddr = ba;
        end else begin
            m_iaddr = m_iaddr + INCV;
        end
        e.iaddr = m_iaddr;
        e.cnt   = CNT_W'(m_stack.size());
        e.full  = (m_stack.size() == DEPTH);
        e.empty = (m_stack.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and record the expectation.
    task automatic step(input logic r, input logic s, input logic b, input logic [ADDR_W-1:0] ba,
                        input logic c, input logic [ADDR_W-1:0] ca, input logic rt);
        @(negedge clk);
        rst = r; stall = s; branch_en = b; branch_addr = ba;
        call_en = c; call_addr = ca; ret_en = rt;
        model_step(r, s, b, ba, c, ca, rt);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask
    task automatic do_rst();
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask
    task automatic do_branch(input logic [ADDR_W-1:0] a);
        step(1'b0, 1'b0, 1'b1, a, 1'b0, 16'h0000, 1'b0);
    endtask
    task automatic do_call(input logic [ADDR_W-1:0] a);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, a, 1'b0);
    endtask
    task automatic do_ret();
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    endtask

    // Wait until the last issued cycle has taken effect.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every edge, compare the DUT outputs with the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_iaddr", 32'(iaddr), 32'(e.iaddr));
            chk("sb_count", 32'(ras_count), 32'(e.cnt));
            chk("sb_full",  32'(ras_full), 32'(e.full));
            chk("sb_empty", 32'(ras_empty), 32'(e.empty));
            chk("sb_ovf",   32'(ras_ovf), 32'(e.ovf));
            chk("sb_unf",   32'(ras_unf), 32'(e.unf));
        end
    end

    initial begin
        // 1: reset, then free-running increments
        do_rst(); do_rst();
        settle();
        chk("rst_iaddr", 32'(iaddr), 32'h0);
        chk("rst_empty", 32'(ras_empty), 32'h1);
        idle(); idle(); idle();
        settle();
        chk("inc_iaddr3", 32'(iaddr), 32'h3);
        chk("inc_count", 32'(ras_count), 32'h0);

        // 2: call and return
        do_branch(16'h0010);
        do_call(16'h0200);
        settle();
        chk("call_iaddr", 32'(iaddr), 32'h0200);
        chk("call_count", 32'(ras_count), 32'h1);
        idle(); idle(); idle();
        do_ret();
        settle();
        chk("ret_iaddr", 32'(iaddr), 32'h0011);
        chk("ret_empty", 32'(ras_empty), 32'h1);

        // 3: nested calls overflow, then drain and underflow
        do_rst();
        for (int i = 0; i < 9; i++) do_call(16'h1000 + 16'(i * 16));
        settle();
        chk("ovf_full", 32'(ras_full), 32'h1);
        chk("ovf_flag", 32'(ras_ovf), 32'h1);
        chk("ovf_count", 32'(ras_count), 32'h8);
        for (int i = 0; i < 8; i++) begin
            do_ret();
            settle();
            chk("lifo_ret", 32'(iaddr), 32'h1071 - 32'(i * 16));
        end
        do_ret();
        settle();
        chk("unf_iaddr", 32'(iaddr), 32'h1002);
        chk("unf_flag", 32'(ras_unf), 32'h1);

        // 4: address wrap
        do_branch(16'hFFFF);
        idle();
        settle();
        chk("wrap_inc", 32'(iaddr), 32'h0000);
        do_branch(16'hFFFF);
        do_call(16'h0300);
        do_ret();
        settle();
        chk("wrap_push", 32'(iaddr), 32'h0000);

        // 5: stall with every request high
        do_call(16'h0400);
        step(1'b0, 1'b1, 1'b1, 16'h0777, 1'b1, 16'h0888, 1'b1);
        settle();
        chk("stall_iaddr", 32'(iaddr), 32'h0400);
        chk("stall_count", 32'(ras_count), 32'h1);

        // 6: ret beats call, then reset mid-nest
        do_rst();
        do_call(16'h0100);
        do_branch(16'h0041);
        do_call(16'h0500);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0999, 1'b1);
        settle();
        chk("retcall_iaddr", 32'(iaddr), 32'h0042);
        chk("retcall_count", 32'(ras_count), 32'h1);
        do_call(16'h0600);
        do_rst();
        settle();
        chk("midrst_iaddr", 32'(iaddr), 32'h0000);
        chk("midrst_count", 32'(ras_count), 32'h0);
        chk("midrst_flags", 32'({ras_ovf, ras_unf}), 32'h0);

        // Randomized traffic, biased toward calls and returns to exercise the stack edges
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0), 16'($urandom),
                 ($urandom_range(0, 2) == 0), 16'($urandom),
                 ($urandom_range(0, 2) == 0));
        end
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
